serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial two's-complement subtractor computing `diff = a - b` one bit per clock, LSB first, as `a + ~b + 1` through a single registered full-adder cell. It is the sequential, inverse-operation counterpart to the combinational 4-bit full adder. Its `diff`/`carryout`/`overflow` outputs use the same flag conventions as that adder, so both blocks are checked against the same expected-value tables. A start/done handshake lets a driver or a future ALU sequencer launch one operation at a time.

## Interface
- `WIDTH`, default 4: operand and result width in bits; legal range 2 to 16.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high; sampled on `clk` rising edge.
- `start`  input  1  launch request; accepted only when `busy` = 0.
- `a`  input  WIDTH  minuend; sampled on the accepting edge only.
- `b`  input  WIDTH  subtrahend; sampled on the accepting edge only.
- `diff`  output  WIDTH  result; registered; held until the next completion.
- `carryout`  output  1  adder carry out of the MSB; 1 = no borrow (unsigned `a >= b`).
- `overflow`  output  1  signed overflow of `a - b`.
- `busy`  output  1  high while an operation is in progress.
- `done`  output  1  single-cycle pulse; high in the cycle `diff`/flags first become valid.

## Operation
- FSM states:
  - IDLE: `busy` = 0.
  - RUN: `busy` = 1.
- IDLE -> RUN on the first edge where `start` = 1. That edge:
  - loads operand shift registers A <= `a` and B <= `~b`;
  - sets internal carry c <= 1;
  - clears the bit counter to 0 and the result shift register.
- Each RUN edge processes bit i = counter:
  - s = A[0] ^ B[0] ^ c;
  - c <= majority(A[0], B[0], c);
  - s is shifted into the result register from the MSB side; A and B shift right;
  - counter increments.
- RUN -> IDLE on the edge where counter = WIDTH-1. That edge also:
  - loads `diff` with the completed result;
  - sets `carryout` <= final carry;
  - sets `overflow` <= (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched operands;
  - sets `done` <= 1.
- `done` clears on the following edge.
- `start` while `busy` = 1 is ignored; the in-flight operation is unaffected.
- `start` in the cycle `done` = 1 is accepted, since the FSM is already in IDLE. Back-to-back operations are therefore possible.
- `a`/`b` may change freely after acceptance.
- `diff`, `carryout` and `overflow` change only on completion edges or on reset.
- Counter width is clog2(WIDTH); the counter never wraps within an operation.

## Timing
- Reset values: `diff` = 0, `carryout` = 0, `overflow` = 0, `busy` = 0, `done` = 0; FSM = IDLE; counter = 0.
- Reset asserted mid-operation aborts the operation on that edge:
  - all outputs return to their reset values;
  - no `done` pulse is issued;
  - `start` in a reset cycle is ignored.
- Latency: with `start` accepted at edge E, `busy` = 1 after E, and `done` = 1 with valid results after edge E+WIDTH. For WIDTH = 4, the result appears 4 cycles after acceptance.
- Throughput: one result per WIDTH cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SERIAL_SUB_ADD_MODE_EN`
  - Defined: adds input port `op` (1 bit, sampled with `a`/`b` on the accepting edge).
    - `op` = 1: subtract; loads B <= `~b`, c <= 1.
    - `op` = 0: add; loads B <= `b`, c <= 0.
  - Defined, overflow for add: (a[MSB] == b[MSB]) && (diff[MSB] != a[MSB]).
  - Not defined: no `op` port; the block always subtracts.
  - Timing and the handshake are identical in both builds.

## Test plan
- Reset, then `a` = 0000, `b` = 0000, start -> `done` exactly 4 cycles later; `diff` = 0000, `carryout` = 1, `overflow` = 0.
- `a` = 0111, `b` = 1111 -> `diff` = 1000, `carryout` = 0, `overflow` = 1. Then `a` = 1000, `b` = 0001 -> `diff` = 0111, `carryout` = 1, `overflow` = 1.
- `a` = 0011, `b` = 0101 -> `diff` = 1110, `carryout` = 0, `overflow` = 0. Then, in the `done` cycle, start with `a` = 1010, `b` = 0010 -> next `done` 4 cycles later with `diff` = 1000, `carryout` = 1, `overflow` = 0.
- Start `a` = 0101, `b` = 0001; pulse `start` with `a` = 1111, `b` = 1111 while `busy` -> the second request is ignored; a single `done` with `diff` = 0100, `carryout` = 1.
- Start an operation and assert `reset` 2 cycles in -> all outputs 0 on the next edge, no `done` pulse; a fresh start afterward completes normally.
- With `SERIAL_SUB_ADD_MODE_EN`: `op` = 0, `a` = 1111, `b` = 0001 -> `diff` = 0000, `carryout` = 1, `overflow` = 0. Then `op` = 0, `a` = 1000, `b` = 1001 -> `diff` = 0001, `carryout` = 1, `overflow` = 1.

Source files
------------

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b via one registered full-adder cell, LSB first; optional add mode under SERIAL_SUB_ADD_MODE_EN
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic             op,
`endif
    output logic [WIDTH-1:0] diff,
    output logic             carryout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             a_msb;
    logic             b_msb;
    logic             sub_op;

    logic             op_in;
    logic             s;
    logic             c_next;
    logic [WIDTH-1:0] res_next;
    logic             ovf_next;

`ifdef SERIAL_SUB_ADD_MODE_EN
    assign op_in = op;
`else
    assign op_in = 1'b1;
`endif

    // Subtract overflows when operand signs differ; add when they match.
    always_comb begin
        s        = a_sh[0] ^ b_sh[0] ^ c;
        c_next   = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
        res_next = {s, res[WIDTH-1:1]};
        ovf_next = ((a_msb ^ b_msb) == sub_op) && (res_next[WIDTH-1] != a_msb);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            cnt      <= '0;
            c        <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            sub_op   <= 1'b1;
            diff     <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= op_in ? ~b : b;
                        c      <= op_in;
                        cnt    <= '0;
                        res    <= '0;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        sub_op <= op_in;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    c    <= c_next;
                    res  <= res_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        diff     <= res_next;
                        carryout <= c_next;
                        overflow <= ovf_next;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
